// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, opcode map and fetch state encoding shared by fetch and control
package cpu_pkg;
  localparam int OPCODE_W = 4;
  localparam int INSTR_W = 16;
  localparam int PC_W = 8;
  localparam int unsigned RESET_PC = 0;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SRL  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_LW   = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_SW   = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_SLT  = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry parking register for a response accepted while decode is stalled
module fetch_skid_buf #(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] data_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               full_o
);
  logic full_q;
  logic [INSTR_W-1:0] data_q;
  logic [PC_W-1:0] pc_q;
  // clear wins over load so a flush never leaves a stale entry behind
  always_ff @(posedge clk) begin
    full_q <= clear_i ? 1'b0 : load_i ? 1'b1 : full_q;
    if (load_i) begin
      data_q <= data_i;
      pc_q <= pc_i;
    end
  end
  assign data_o = data_q;
  assign pc_o = pc_q;
  assign full_o = full_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues single-outstanding imem fetches and holds the IF/ID register
module instruction_fetch_unit #(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [PC_W-1:0]               redirect_pc,
  output logic                          imem_req,
  output logic [PC_W-1:0]               imem_addr,
  input  logic                          imem_valid,
  input  logic [INSTR_W-1:0]            imem_rdata,
  output logic [INSTR_W-1:0]            instr,
  output logic [cpu_pkg::OPCODE_W-1:0]  opcode,
  output logic [PC_W-1:0]               instr_pc,
  output logic                          instr_valid
);
  import cpu_pkg::*;
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, instr_pc_q, instr_pc_d, skid_pc;
  logic [INSTR_W-1:0] instr_q, instr_d, skid_data;
  logic instr_valid_q, instr_valid_d, skid_full;
  logic flush, accept, park, release_skid;
  assign flush = reset | redirect;
  assign pc_inc = pc_q + PC_W'(1);
  assign accept = state_q == S_WAIT && imem_valid;
  assign park = accept && stall;
  assign release_skid = state_q == S_HOLD && !stall;
  assign imem_req = !flush && (state_q == S_IDLE || (accept && !stall) || release_skid);
  assign imem_addr = imem_req ? (accept ? pc_inc : pc_q) : '0;
  assign instr = instr_q;
  assign opcode = instr_q[INSTR_W-1 -: OPCODE_W];
  assign instr_pc = instr_pc_q;
  assign instr_valid = instr_valid_q;
  fetch_skid_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk(clk),
    .load_i(park && !flush),
    .clear_i(flush || release_skid),
    .data_i(imem_rdata),
    .pc_i(pc_q),
    .data_o(skid_data),
    .pc_o(skid_pc),
    .full_o(skid_full)
  );
  // a flush with a response still in flight must swallow it, hence S_DROP
  always_comb begin
    state_d = flush ? (((state_q == S_WAIT || state_q == S_DROP) && !imem_valid) ? S_DROP : S_IDLE)
            : state_q == S_IDLE ? S_WAIT
            : state_q == S_DROP ? (imem_valid ? S_IDLE : S_DROP)
            : park ? S_HOLD
            : release_skid ? S_WAIT
            : state_q;
    pc_d = redirect ? redirect_pc : accept ? pc_inc : pc_q;
    instr_valid_d = redirect ? 1'b0 : stall ? instr_valid_q : accept | (release_skid & skid_full);
    instr_d = (redirect || stall) ? instr_q : release_skid ? skid_data : accept ? imem_rdata : instr_q;
    instr_pc_d = (redirect || stall) ? instr_pc_q : release_skid ? skid_pc : accept ? pc_q : instr_pc_q;
  end
  // PC and IF/ID register; state reset is folded into state_d so in-flight responses are tracked
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_W'(RESET_PC);
      instr_q <= '0;
      instr_pc_q <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
    state_q <= state_d;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random fetch traffic against a transaction-level model
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, stall = 1'b0, redirect = 1'b0, imem_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic [15:0] imem_rdata = '0;
  logic imem_req, instr_valid;
  logic [7:0] imem_addr, instr_pc;
  logic [15:0] instr;
  logic [3:0] opcode;
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );
  logic s_reset = 1'b1, s_vld = 1'b0, s_req, s_valid;
  logic [3:0] s_addr, s_ipc, s_op;
  logic [15:0] s_rdata = '0, s_instr;
  instruction_fetch_unit #(.PC_W(4), .RESET_PC(15)) dut_w (
    .clk(clk), .reset(s_reset), .stall(1'b0), .redirect(1'b0), .redirect_pc(4'h0),
    .imem_req(s_req), .imem_addr(s_addr), .imem_valid(s_vld), .imem_rdata(s_rdata),
    .instr(s_instr), .opcode(s_op), .instr_pc(s_ipc), .instr_valid(s_valid)
  );
  // one-cycle memory for the narrow-PC instance
  always @(posedge clk) begin
    s_vld <= s_req;
    s_rdata <= {4'hA, 8'h00, s_addr};
  end
  int n_cmp = 0, n_bad = 0;
  logic [15:0] rom [256];
  bit mo = 0;
  int mcnt = 0, lat = 1;
  logic [7:0] maddr = '0;
  logic [15:0] e_instr = '0, pk_d = '0;
  logic [7:0] e_pc = '0, e_addr = '0, pk_pc = '0;
  bit e_valid = 0, pk = 0, stale = 0;
  bit seen_req;
  logic [7:0] seen_addr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit rd, input logic [7:0] rpc, input bit s);
    bit resp, ok, exp_req;
    logic [7:0] a;
    reset = r;
    redirect = rd;
    redirect_pc = rpc;
    stall = s;
    resp = mo && mcnt == 1;
    a = maddr;
    imem_valid = resp;
    imem_rdata = resp ? rom[a] : 16'($urandom);
    if (mo && !resp) mcnt--;
    ok = resp && !stale;
    exp_req = !r && !rd && (mo ? (ok && !s) : (!pk || !s));
    if (r || rd) begin
      e_valid = 0;
      pk = 0;
      stale = mo && !resp;
      e_addr = r ? 8'h00 : rpc;
      if (r) begin
        e_instr = '0;
        e_pc = '0;
      end
    end else begin
      if (resp) stale = 0;
      if (ok) e_addr = a + 8'd1;
      if (!s) begin
        if (pk) begin
          e_instr = pk_d; e_pc = pk_pc; e_valid = 1; pk = 0;
        end else if (ok) begin
          e_instr = rom[a]; e_pc = a; e_valid = 1;
        end else e_valid = 0;
      end else if (ok) begin
        pk = 1; pk_d = rom[a]; pk_pc = a;
      end
    end
    #1;
    seen_req = imem_req;
    seen_addr = imem_addr;
    chk("req", seen_req, exp_req);
    if (seen_req) chk("addr", seen_addr, e_addr);
    if (seen_req) begin
      maddr = seen_addr; mcnt = lat; mo = 1;
    end else if (resp) mo = 0;
    @(posedge clk);
    @(negedge clk);
    chk("instr_valid", instr_valid, e_valid);
    if (e_valid || r) begin
      chk("instr", instr, e_instr);
      chk("instr_pc", instr_pc, e_pc);
      chk("opcode", opcode, e_instr[15:12]);
    end
  endtask
  task automatic reset_seq();
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", seen_req, 0);
    step(0, 0, 8'h00, 0);
    chk("first_req", seen_req, 1);
    chk("first_addr", seen_addr, 8'h00);
  endtask
  initial begin
    logic [3:0] ops [3];
    logic [3:0] wexp;
    bit got;
    ops[0] = 4'h1; ops[1] = 4'h2; ops[2] = 4'hD;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h1234; rom[1] = 16'h2ABC; rom[2] = 16'hD001;
    @(negedge clk);
    lat = 1;
    reset_seq();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 0);
      chk("stream_op", opcode, ops[i]);
      chk("stream_pc", instr_pc, i);
      chk("stream_valid", instr_valid, 1);
    end
    reset_seq();
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1);
      chk("stall_hold_pc", instr_pc, 8'h00);
      chk("stall_noreq", seen_req, 0);
    end
    step(0, 0, 8'h00, 0);
    chk("stall_release_pc", instr_pc, 8'h01);
    chk("stall_release_op", opcode, 4'h2);
    lat = 3;
    reset_seq();
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h40, 0);
    chk("redir_bubble", instr_valid, 0);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(0, 0, 8'h00, 0);
      chk("redir_drop_valid", instr_valid, 0);
      got = seen_req;
    end
    chk("redir_seen_req", got, 1);
    chk("redir_addr", seen_addr, 8'h40);
    lat = 1;
    reset_seq();
    step(0, 1, 8'h80, 1);
    chk("redir_same_req", seen_req, 0);
    chk("redir_same_valid", instr_valid, 0);
    step(0, 0, 8'h00, 1);
    chk("redir_same_next_req", seen_req, 1);
    chk("redir_same_next_addr", seen_addr, 8'h80);
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
    end
    s_reset = 1'b0;
    @(negedge clk);
    chk("wrap_first_bubble", s_valid, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      wexp = 4'(15 + j);
      chk("wrap_valid", s_valid, 1);
      chk("wrap_pc", s_ipc, wexp);
      chk("wrap_instr", s_instr, {4'hA, 8'h00, wexp});
      chk("wrap_op", s_op, 4'hA);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
